mux_scan: RTL and testbench
===========================

MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 Parameter NUM_CH, default 7, number of input channels, legal range 2..64.
REQ-002 Parameter WIDTH, default 1, bits per channel, legal range 1..32.
REQ-003 Parameter DWELL, default 4, clock cycles spent on each channel in scan mode, legal range 1..1024.
REQ-004 Derived: SELW = ceil(log2(NUM_CH)), minimum 1; DW = ceil(log2(DWELL)), minimum 1.
REQ-005 Port: clock, input, 1, the single clock; all state changes on its rising edge.
REQ-006 Port: resetn, input, 1, asynchronous active-low reset.
REQ-007 Port: data_in, input, NUM_CH*WIDTH; channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-008 Port: sel, input, SELW; channel select in manual mode.
REQ-009 Port: mode, input, 1; 0 = manual, 1 = auto-scan.
REQ-010 Port: hold, input, 1; freezes the scan position in auto-scan mode.
REQ-011 Port: out, output, WIDTH; registered selected channel data.
REQ-012 Port: ch, output, SELW; registered index of the channel currently presented on out.
REQ-013 Port: err, output, 1; registered flag, high when the manual sel is out of range (sel >= NUM_CH).
REQ-014 Port: wrap, output, 1; registered one-cycle pulse marking scan wrap from NUM_CH-1 to 0.

Function
REQ-015 The FSM SHALL have three states: MANUAL, SCAN and PAUSE.
REQ-016 Transitions SHALL be:
- MANUAL -> SCAN when mode=1.
- SCAN -> PAUSE when mode=1 and hold=1.
- PAUSE -> SCAN when mode=1 and hold=0.
- SCAN or PAUSE -> MANUAL when mode=0, regardless of hold.
REQ-017 MANUAL:
- Each cycle, ch <= sel and err <= 0 when sel < NUM_CH.
- Otherwise ch is unchanged, err <= 1 and out <= 0.
REQ-018 out SHALL equal the data_in slice of channel ch, sampled one cycle earlier: one-cycle latency from data_in/sel to out, with out and ch updated together in the same register stage.
REQ-019 SCAN:
- A dwell counter counts 0..DWELL-1.
- At DWELL-1 the counter clears and ch advances by 1.
- At NUM_CH-1, ch wraps to 0 and wrap pulses high for exactly one cycle, coincident with ch becoming 0.
REQ-020 With DWELL=1, ch SHALL advance every cycle in SCAN.
REQ-021 PAUSE: ch and the dwell counter are frozen; out continues to track live data_in of the frozen ch each cycle.
REQ-022 Entering SCAN from MANUAL SHALL start at the current ch with the dwell counter cleared to 0.
- If the entry coincides with err=1, ch stays at its last valid value.
REQ-023 Resuming PAUSE -> SCAN SHALL continue from the frozen counter value; the count is not restarted.
REQ-024 err SHALL be 0 in SCAN and PAUSE.
REQ-025 wrap SHALL be 0 in all states and cycles other than those defined in REQ-019.
REQ-026 All registers SHALL be fully synchronous to clock except for the asynchronous reset.
REQ-027 No combinational path SHALL exist from any input to any output.

Reset
REQ-028 While resetn=0, the block SHALL asynchronously force: state = MANUAL, ch = 0, dwell counter = 0, out = 0, err = 0, wrap = 0.
REQ-029 After resetn rises, the first rising clock edge SHALL perform normal operation per the current inputs.
REQ-030 Reset asserted mid-scan or mid-pause SHALL abandon the position; after release, the block restarts in MANUAL from ch = 0.

Verification
REQ-031 Manual select: NUM_CH=7, WIDTH=1, data_in=7'b1010110, mode=0, sel=2 -> next edge: ch=2, out=1, err=0; sel=0 -> out=0 one edge later.
REQ-032 Out of range: NUM_CH=7, sel=7 -> next edge: err=1, out=0, ch holds previous value; sel=3 -> err=0 next edge.
REQ-033 Scan and wrap: NUM_CH=7, DWELL=4, mode=1 from ch=5 -> ch=5 for 4 cycles, ch=6 for 4, then ch=0 with wrap=1 for one cycle only.
REQ-034 Hold: in SCAN at dwell count 2 on ch=3, assert hold for 10 cycles -> ch stays 3, out follows toggling data_in[3]; release -> ch=4 after 2 more edges.
REQ-035 Reset mid-operation: resetn pulled low between edges during SCAN at ch=4 -> outputs 0 immediately, without a clock; release with mode=0, sel=6 -> ch=6 after the first edge.
REQ-036 Parameter sweep: NUM_CH=2 with DWELL=1, and NUM_CH=16 with WIDTH=8 -> correct slice selection, every-cycle advance, and a wrap pulse every NUM_CH*DWELL cycles.

Source files
------------

// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - channel multiplexer with manual select and timed auto-scan
// Registered out/ch/err/wrap; ch and out always move together in one stage.
module mux_scan #(
   parameter int NUM_CH = 7,
   parameter int WIDTH  = 1,
   parameter int DWELL  = 4,
   localparam int SELW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int DW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
   input  logic                    clock,
   input  logic                    resetn,
   input  logic [NUM_CH*WIDTH-1:0] data_in,
   input  logic [SELW-1:0]         sel,
   input  logic                    mode,
   input  logic                    hold,
   output logic [WIDTH-1:0]        out,
   output logic [SELW-1:0]         ch,
   output logic                    err,
   output logic                    wrap
);
   typedef enum logic [1:0] {MANUAL, SCAN, PAUSE} state_t;

   localparam logic [SELW:0]   CH_COUNT = (SELW + 1)'(NUM_CH);
   localparam logic [SELW-1:0] CH_LAST  = SELW'(NUM_CH - 1);
   localparam logic [DW-1:0]   CNT_LAST = DW'(DWELL - 1);

   state_t           state;
   logic [DW-1:0]    cnt;
   logic             sel_ok;
   logic             sel_bad;
   logic [SELW-1:0]  ch_next;
   logic [DW-1:0]    cnt_next;
   logic             wrap_next;
   logic [WIDTH-1:0] slice [NUM_CH];

   for (genvar k = 0; k < NUM_CH; k++) begin : g_slice
      assign slice[k] = data_in[k*WIDTH +: WIDTH];
   end

   assign sel_ok  = {1'b0, sel} < CH_COUNT;
   assign sel_bad = !mode && !sel_ok;

   // Next scan position; entering scan keeps the current ch but restarts the dwell count.
   always_comb begin
      ch_next   = ch;
      cnt_next  = cnt;
      wrap_next = 1'b0;
      if (!mode) begin
         cnt_next = '0;
         if (sel_ok) ch_next = sel;
      end else if (state == MANUAL) begin
         cnt_next = '0;
      end else if (!hold) begin
         if (cnt == CNT_LAST) begin
            cnt_next = '0;
            if (ch == CH_LAST) begin
               ch_next   = '0;
               wrap_next = 1'b1;
            end else begin
               ch_next = ch + 1'b1;
            end
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= MANUAL;
         ch    <= '0;
         cnt   <= '0;
         out   <= '0;
         err   <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         ch   <= ch_next;
         cnt  <= cnt_next;
         wrap <= wrap_next;
         err  <= sel_bad;
         out  <= sel_bad ? '0 : slice[ch_next];
         case (state)
            MANUAL: if (mode) state <= SCAN;
            SCAN: begin
               if (!mode)     state <= MANUAL;
               else if (hold) state <= PAUSE;
            end
            PAUSE: begin
               if (!mode)      state <= MANUAL;
               else if (!hold) state <= SCAN;
            end
            default: state <= MANUAL;
         endcase
      end
   end
endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - scoreboard bench for mux_scan over three parameter sets
// The model tracks scan position as one phase number modulo NUM_CH*DWELL.
module tb_mux_scan;
   localparam int N0 = 7,  W0 = 1, D0 = 4;
   localparam int N1 = 2,  W1 = 1, D1 = 1;
   localparam int N2 = 16, W2 = 8, D2 = 2;
   localparam int NC [3] = '{N0, N1, N2};
   localparam int WD [3] = '{W0, W1, W2};
   localparam int DL [3] = '{D0, D1, D2};

   typedef struct packed {
      logic [7:0] o;
      logic [3:0] c;
      logic       e;
      logic       w;
   } exp_t;

   logic clock, resetn, mode, hold;
   logic [6:0]   d0;
   logic [1:0]   d1;
   logic [127:0] d2;
   logic [2:0] s0, c0;
   logic [0:0] s1, c1;
   logic [3:0] s2, c2;
   logic [0:0] o0, o1;
   logic [7:0] o2;
   logic e0, e1, e2, w0, w1, w2;

   exp_t q0[$], q1[$], q2[$];
   int   passed = 0, total = 0;
   int   m_p [3];
   bit   m_scan [3];

   mux_scan #(.NUM_CH(N0), .WIDTH(W0), .DWELL(D0)) u0 (
      .clock(clock), .resetn(resetn), .data_in(d0), .sel(s0), .mode(mode), .hold(hold),
      .out(o0), .ch(c0), .err(e0), .wrap(w0));
   mux_scan #(.NUM_CH(N1), .WIDTH(W1), .DWELL(D1)) u1 (
      .clock(clock), .resetn(resetn), .data_in(d1), .sel(s1), .mode(mode), .hold(hold),
      .out(o1), .ch(c1), .err(e1), .wrap(w1));
   mux_scan #(.NUM_CH(N2), .WIDTH(W2), .DWELL(D2)) u2 (
      .clock(clock), .resetn(resetn), .data_in(d2), .sel(s2), .mode(mode), .hold(hold),
      .out(o2), .ch(c2), .err(e2), .wrap(w2));

   initial begin
      clock = 0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string nm, input int got, input int want);
      total++;
      if (got == want) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
   endtask

   task automatic cmp(input int k, input exp_t e, input int ao, input int ac, input int ae, input int aw);
      chk($sformatf("i%0d out", k), ao, int'(e.o));
      chk($sformatf("i%0d ch", k), ac, int'(e.c));
      chk($sformatf("i%0d err", k), ae, int'(e.e));
      chk($sformatf("i%0d wrap", k), aw, int'(e.w));
   endtask

   function automatic exp_t model(input int k, input bit md, input bit hd, input int s, input logic [127:0] d);
      exp_t r;
      r = '0;
      if (!md) begin
         m_scan[k] = 0;
         if (s < NC[k]) m_p[k] = s * DL[k];
         else r.e = 1'b1;
      end else if (!m_scan[k]) begin
         m_scan[k] = 1;
         m_p[k] = (m_p[k] / DL[k]) * DL[k];
      end else if (!hd) begin
         m_p[k] = (m_p[k] + 1) % (NC[k] * DL[k]);
         r.w = (m_p[k] == 0);
      end
      r.c = 4'(m_p[k] / DL[k]);
      if (!r.e)
         for (int b = 0; b < WD[k]; b++) r.o[b] = d[int'(r.c) * WD[k] + b];
      return r;
   endfunction

   function automatic logic [127:0] r128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic cycle(input bit rn, input bit md, input bit hd, input int a0, input int a1, input int a2,
                        input logic [127:0] x0, input logic [127:0] x1, input logic [127:0] x2);
      @(negedge clock);
      resetn = rn; mode = md; hold = hd;
      s0 = 3'(a0); s1 = 1'(a1); s2 = 4'(a2);
      d0 = x0[6:0]; d1 = x1[1:0]; d2 = x2;
      if (!rn) begin
         #1;
         chk("async reset", int'({o0, o1, o2, c0, c1, c2, e0, e1, e2, w0, w1, w2}), 0);
         for (int k = 0; k < 3; k++) begin
            m_p[k] = 0;
            m_scan[k] = 0;
         end
         q0.push_back(exp_t'(0));
         q1.push_back(exp_t'(0));
         q2.push_back(exp_t'(0));
      end else begin
         q0.push_back(model(0, md, hd, int'(s0), {121'b0, d0}));
         q1.push_back(model(1, md, hd, int'(s1), {126'b0, d1}));
         q2.push_back(model(2, md, hd, int'(s2), d2));
      end
   endtask

   always @(posedge clock) begin
      exp_t e;
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         cmp(0, e, int'(o0), int'(c0), int'(e0), int'(w0));
         e = q1.pop_front();
         cmp(1, e, int'(o1), int'(c1), int'(e1), int'(w1));
         e = q2.pop_front();
         cmp(2, e, int'(o2), int'(c2), int'(e2), int'(w2));
      end
   end

   initial begin
      logic [127:0] pat;
      bit md, hd, rn;
      pat = 128'b1010110;
      resetn = 1; mode = 0; hold = 0;
      s0 = 0; s1 = 0; s2 = 0; d0 = 0; d1 = 0; d2 = 0;
      #2 resetn = 0;
      cycle(0, 0, 0, 0, 0, 0, r128(), r128(), r128());
      cycle(0, 0, 0, 0, 0, 0, r128(), r128(), r128());
      // manual select and out-of-range
      foreach (pat[i]) if (i < 1) ;
      cycle(1, 0, 0, 2, 1, 9, pat, r128(), r128());
      cycle(1, 0, 0, 0, 0, 3, pat, r128(), r128());
      cycle(1, 0, 0, 7, 1, 15, pat, r128(), r128());
      cycle(1, 0, 0, 3, 0, 4, pat, r128(), r128());
      // scan from ch 5 through a wrap
      cycle(1, 0, 0, 5, 1, 14, r128(), r128(), r128());
      for (int i = 0; i < 14; i++) cycle(1, 1, 0, 0, 0, 0, r128(), r128(), r128());
      // hold at dwell count 2 on ch 3 with toggling channel 3
      cycle(1, 0, 0, 3, 0, 1, pat, r128(), r128());
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, pat, r128(), r128());
      for (int i = 0; i < 10; i++)
         cycle(1, 1, 1, 0, 0, 0, pat ^ ((i % 2) ? 128'h8 : 128'h0), r128(), r128());
      for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, pat, r128(), r128());
      // reset mid-scan, release in manual on ch 6
      cycle(0, 1, 0, 0, 0, 0, r128(), r128(), r128());
      cycle(1, 0, 0, 6, 1, 12, r128(), r128(), r128());
      // long scan exercising wrap for every parameter set
      for (int i = 0; i < 40; i++) cycle(1, 1, 0, 0, 0, 0, r128(), r128(), r128());
      // randomized traffic
      md = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(15) == 0) md = ~md;
         hd = ($urandom_range(3) == 0);
         rn = ($urandom_range(199) != 0);
         cycle(rn, md, hd, int'($urandom_range(7)), int'($urandom_range(1)), int'($urandom_range(15)),
               r128(), r128(), r128());
      end
      @(negedge clock);
      @(negedge clock);
      chk("drain", q0.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
